// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment check for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_X || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and extraction/extension for loads
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);
  logic [4:0]  sh;
  logic [31:0] rd_sh;
  always_comb begin
    sh = {off, 3'b000};
    wdata_sh = wdata << sh;
    wmask = size == SZ_W ? 32'hFFFF_FFFF : (size == SZ_H ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    rd_sh = rdata >> sh;
    rdata_ext = size == SZ_B ? {{24{~uns & rd_sh[7]}}, rd_sh[7:0]} :
                size == SZ_H ? {{16{~uns & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
  end
endmodule

// File: rtl/lsu_dmem.sv
// lsu_dmem: single-outstanding load/store unit driving a word-addressed data memory port
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            dmem_ren,
  output logic [XLEN-1:0] dmem_raddr,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_waddr,
  output logic [XLEN-1:0] dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata
);
  lsu_state_t  state;
  logic        wen_r, uns_r, fault_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, rdata_r, rdata_ext;
  lsu_align u_align (
    .size      (size_r),
    .off       (addr_r[1:0]),
    .uns       (uns_r),
    .wdata     (wdata_r),
    .rdata     (dmem_rdata),
    .wmask     (dmem_wmask),
    .wdata_sh  (dmem_wdata),
    .rdata_ext (rdata_ext)
  );
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    resp_rdata = rdata_r;
    resp_fault = fault_r;
    dmem_ren   = state == ACCESS && !wen_r;
    dmem_wen   = state == ACCESS && wen_r && !reset;
    dmem_raddr = {addr_r[31:2], 2'b00};
    dmem_waddr = {addr_r[31:2], 2'b00};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rdata_r <= '0;
      fault_r <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        wen_r   <= req_wen;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        size_r  <= req_size;
        uns_r   <= req_unsigned;
        if (misaligned(req_size, req_addr[1:0])) begin
          fault_r <= 1'b1;
          rdata_r <= '0;
          state   <= RESP;
        end else begin
          state <= ACCESS;
        end
      end
    end else if (state == ACCESS) begin
      rdata_r <= wen_r ? '0 : rdata_ext;
      fault_r <= 1'b0;
      state   <= RESP;
    end else if (resp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed checks of lsu_dmem against a small word memory
module tb_lsu_dmem;
  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_fault, dmem_ren, dmem_wen;
  logic [31:0] resp_rdata, dmem_raddr, dmem_rdata, dmem_waddr, dmem_wmask, dmem_wdata;
  logic [31:0] mem [0:15];
  int          checks = 0, errors = 0, wr_count = 0, ren_count = 0;
  lsu_dmem dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_wen(dmem_wen), .dmem_waddr(dmem_waddr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata)
  );
  always #5 clock = ~clock;
  assign dmem_rdata = mem[dmem_raddr[5:2]];
  always @(posedge clock) begin
    if (dmem_wen) begin
      mem[dmem_waddr[5:2]] <= (mem[dmem_waddr[5:2]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
      wr_count <= wr_count + 1;
    end
    if (dmem_ren) ren_count <= ren_count + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns);
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    step();
    req_valid = 1'b0;
  endtask
  task automatic handshake();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("req_ready_after_handshake", {31'b0, req_ready}, 32'd1);
  endtask
  task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp);
    send(1'b0, addr, 32'h0, size, uns);
    check({tag, "_ren"}, {31'b0, dmem_ren}, 32'd1);
    check({tag, "_raddr"}, dmem_raddr, addr & ~32'd3);
    check({tag, "_valid_early"}, {31'b0, resp_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_fault"}, {31'b0, resp_fault}, 32'd0);
    handshake();
  endtask
  task automatic fault_req(input string tag, input logic wen, input logic [31:0] addr, input logic [1:0] size);
    int r0, w0;
    r0 = ren_count; w0 = wr_count;
    send(wen, addr, 32'hFFFF_FFFF, size, 1'b0);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_fault"}, {31'b0, resp_fault}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
    handshake();
    check({tag, "_no_ren"}, ren_count, r0);
    check({tag, "_no_wen"}, wr_count, w0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h80FF7F01;
    mem[1] = 32'h11223344;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_fault", {31'b0, resp_fault}, 32'd0);
    check("rst_ren", {31'b0, dmem_ren}, 32'd0);
    check("rst_wen", {31'b0, dmem_wen}, 32'd0);
    load("lb_signed", 32'h80000003, 2'b00, 1'b0, 32'hFFFFFF80);
    load("lbu", 32'h80000003, 2'b00, 1'b1, 32'h00000080);
    load("lhu", 32'h80000002, 2'b01, 1'b1, 32'h000080FF);
    load("lh_signed", 32'h80000002, 2'b01, 1'b0, 32'hFFFF80FF);
    load("lh_pos", 32'h80000000, 2'b01, 1'b0, 32'h00007F01);
    load("lb_off1", 32'h80000001, 2'b00, 1'b0, 32'h0000007F);
    send(1'b1, 32'h80000006, 32'h1234ABCD, 2'b01, 1'b0);
    check("sh_wen", {31'b0, dmem_wen}, 32'd1);
    check("sh_waddr", dmem_waddr, 32'h80000004);
    check("sh_wmask", dmem_wmask, 32'hFFFF0000);
    check("sh_wdata", dmem_wdata, 32'hABCD0000);
    check("sh_ren", {31'b0, dmem_ren}, 32'd0);
    step();
    check("sh_valid", {31'b0, resp_valid}, 32'd1);
    check("sh_rdata", resp_rdata, 32'h0);
    check("sh_fault", {31'b0, resp_fault}, 32'd0);
    check("sh_one_write", wr_count, 32'd1);
    handshake();
    load("lw_after_sh", 32'h80000004, 2'b10, 1'b0, 32'hABCD3344);
    send(1'b1, 32'h80000009, 32'h00000055, 2'b00, 1'b0);
    check("sb_wmask", dmem_wmask, 32'h0000FF00);
    check("sb_wdata", dmem_wdata, 32'h00005500);
    step();
    handshake();
    check("sb_mem", mem[2], 32'h00005500);
    fault_req("lw_misaligned", 1'b0, 32'h80000001, 2'b10);
    fault_req("size_illegal", 1'b0, 32'h80000000, 2'b11);
    fault_req("sh_misaligned", 1'b1, 32'h80000003, 2'b01);
    send(1'b0, 32'h80000000, 32'h0, 2'b10, 1'b0);
    step();
    req_valid = 1'b1; req_addr = 32'h80000004; req_size = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'h80FF7F01);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    req_valid = 1'b0;
    handshake();
    load("after_bp", 32'h80000004, 2'b10, 1'b0, 32'hABCD3344);
    send(1'b1, 32'h80000008, 32'hDEADBEEF, 2'b10, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_mid_wen", {31'b0, dmem_wen}, 32'd0);
    step();
    reset = 1'b0;
    check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mid_mem", mem[2], 32'h00005500);
    check("rst_mid_writes", wr_count, 32'd2);
    step();
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
